// File: rtl/turbo_pkg.sv
// Shared constants and types for the turbo decoder LLR datapath.
// Holds the default frame geometry, the LLR sample type and the permutation mode encodings.
package turbo_pkg;

  localparam int DEF_DATA_SIZE  = 11;
  localparam int DEF_BLOCK_SIZE = 21;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_STEP       = 5;
  localparam int DEF_OFFSET     = 0;

  typedef logic signed [DEF_DATA_SIZE-1:0] llr_t;

  localparam logic MODE_INTLV   = 1'b0;
  localparam logic MODE_DEINTLV = 1'b1;

endpackage

// File: rtl/llr_perm_addr.sv
// Frame index counter with an incrementally generated permuted address pi(idx) = (STEP*idx + OFFSET) mod K.
// No multiplier is used: the permuted address steps by STEP, with a single conditional subtraction of K.
module llr_perm_addr #(
  parameter int K      = 21,
  parameter int ADDR_W = 5,
  parameter int STEP   = 5,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_idx,
  output logic [ADDR_W-1:0] o_perm,
  output logic              o_last
);

  localparam logic [ADDR_W:0]   K_W      = (ADDR_W+1)'(K);
  localparam logic [ADDR_W:0]   STEP_W   = (ADDR_W+1)'(STEP);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(K-1);
  localparam logic [ADDR_W-1:0] OFF_W    = ADDR_W'(OFFSET);

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_perm;
  logic [ADDR_W:0]   w_sum;
  logic [ADDR_W-1:0] w_perm_next;

  // Both operands are below K, so one subtraction always brings the sum back into range.
  always_comb begin
    w_sum       = {1'b0, r_perm} + STEP_W;
    w_perm_next = w_sum[ADDR_W-1:0];
    if (w_sum >= K_W) begin
      w_perm_next = ADDR_W'(w_sum - K_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_perm <= OFF_W;
    end else if (i_clear || (i_advance && (r_idx == LAST_IDX))) begin
      r_idx  <= '0;
      r_perm <= OFF_W;
    end else if (i_advance) begin
      r_idx  <= r_idx + 1'b1;
      r_perm <= w_perm_next;
    end
  end

  assign o_idx  = r_idx;
  assign o_perm = r_perm;
  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/llr_interleaver.sv
// Ping-pong extrinsic LLR buffer that replays each frame in interleaved or deinterleaved order.
// Optional build macro EXT_SCALE_EN scales every accepted sample by 0.75 before it is stored.
module llr_interleaver
  import turbo_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STEP       = DEF_STEP,
  parameter int OFFSET     = DEF_OFFSET
) (
  input  logic                        clk_p_i,
  input  logic                        reset_p_i,
  input  logic                        mode_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic signed [DATA_SIZE-1:0] in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [DATA_SIZE-1:0] out_data_o,
  output logic                        out_last_o
);

  localparam int K = BLOCK_SIZE;

  logic signed [DATA_SIZE-1:0] r_mem [2][K];
  logic [1:0]                  r_full;
  logic [1:0]                  r_mode;
  logic                        r_wb;
  logic                        r_rb;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic signed [DATA_SIZE-1:0] r_out_data;

  logic [ADDR_W-1:0]           w_widx, w_wperm, w_waddr;
  logic [ADDR_W-1:0]           w_ridx, w_rperm, w_raddr;
  logic                        w_wlast, w_rlast;
  logic                        w_wr, w_rd, w_wmode;
  logic signed [DATA_SIZE-1:0] w_wdata;
  logic signed [DATA_SIZE-1:0] w_rdata;

  assign in_ready_o = !reset_p_i && !r_full[r_wb];
  assign w_wr       = in_valid_i && in_ready_o;

  // The first sample of a frame uses the live mode input; later samples use the latched bank mode.
  assign w_wmode = (w_widx == '0) ? mode_i : r_mode[r_wb];
  assign w_waddr = (w_wmode == MODE_DEINTLV) ? w_wperm : w_widx;

`ifdef EXT_SCALE_EN
  assign w_wdata = (in_data_i >>> 1) + (in_data_i >>> 2);
`else
  assign w_wdata = in_data_i;
`endif

  // The output register refills whenever it is empty or being consumed, giving one sample per cycle.
  assign w_rd    = r_full[r_rb] && (!r_out_valid || out_ready_i);
  assign w_raddr = (r_mode[r_rb] == MODE_INTLV) ? w_rperm : w_ridx;
  assign w_rdata = r_mem[r_rb][w_raddr];

  llr_perm_addr #(
    .K      (K),
    .ADDR_W (ADDR_W),
    .STEP   (STEP),
    .OFFSET (OFFSET)
  ) u_wr_addr (
    .clk       (clk_p_i),
    .rst       (reset_p_i),
    .i_clear   (1'b0),
    .i_advance (w_wr),
    .o_idx     (w_widx),
    .o_perm    (w_wperm),
    .o_last    (w_wlast)
  );

  llr_perm_addr #(
    .K      (K),
    .ADDR_W (ADDR_W),
    .STEP   (STEP),
    .OFFSET (OFFSET)
  ) u_rd_addr (
    .clk       (clk_p_i),
    .rst       (reset_p_i),
    .i_clear   (1'b0),
    .i_advance (w_rd),
    .o_idx     (w_ridx),
    .o_perm    (w_rperm),
    .o_last    (w_rlast)
  );

  always_ff @(posedge clk_p_i) begin
    if (w_wr) begin
      r_mem[r_wb][w_waddr] <= w_wdata;
    end
  end

  // A write only targets a non-full bank and a read only a full one, so the two never touch the same flag.
  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_full      <= '0;
      r_mode      <= '0;
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_wr) begin
        if (w_widx == '0) begin
          r_mode[r_wb] <= mode_i;
        end
        if (w_wlast) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= ~r_wb;
        end
      end
      if (!r_out_valid || out_ready_i) begin
        r_out_valid <= r_full[r_rb];
      end
      if (w_rd) begin
        r_out_data <= w_rdata;
        r_out_last <= w_rlast;
        if (w_rlast) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= ~r_rb;
        end
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_llr_interleaver.sv
// Directed bench for llr_interleaver: interleave/deinterleave order, back-pressure, ping-pong,
// reset mid-frame and input scaling, each compared against hand-computed permutation tables.
module tb_llr_interleaver;

  localparam int K = 21;

  logic               clk;
  logic               rst;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic signed [10:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] out_data;
  logic               out_last;

  int checks   = 0;
  int failures = 0;
  int write_cycles;

  // out[j] = in[5j mod 21] for interleave; out[j] = in[17j mod 21] for deinterleave.
  int intlv_tab [K] = '{0, 5, 10, 15, 20, 4, 9, 14, 19, 3, 8, 13, 18, 2, 7, 12, 17, 1, 6, 11, 16};
  int dintlv_tab[K] = '{0, 17, 13, 9, 5, 1, 18, 14, 10, 6, 2, 19, 15, 11, 7, 3, 20, 16, 12, 8, 4};
  int wdata     [K];

  logic signed [10:0] got_data[$];
  logic               got_last[$];

  llr_interleaver dut (
    .clk_p_i     (clk),
    .reset_p_i   (rst),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A transfer decided at this falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  function automatic logic signed [10:0] stored(input int x);
    logic signed [10:0] v;
    v = 11'(x);
`ifdef EXT_SCALE_EN
    return (v >>> 1) + (v >>> 2);
`else
    return v;
`endif
  endfunction

  task automatic set_frame(input int base);
    for (int i = 0; i < K; i++) wdata[i] = base + i;
  endtask

  task automatic write_frame(input logic m, input logic flip, input int n);
    logic acc;
    int   waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 11'(wdata[i]);
      mode     = (i == 0 || !flip) ? m : ~m;
      acc      = 1'b0;
      waited   = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        waited++;
        write_cycles++;
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL write_accept sample=%0d in_ready stayed %b, required 1", i, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int waited;
    waited = 0;
    while (got_data.size() < n && waited < 500) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() != n) begin
      failures++;
      $display("FAIL %s_count got=%0d required=%0d", name, got_data.size(), n);
    end
  endtask

  task automatic check_frame(input string name, input int off, input int base, input logic m);
    logic signed [10:0] exp_d;
    logic               exp_l;
    for (int j = 0; j < K; j++) begin
      exp_d = stored(base + ((m == 1'b0) ? intlv_tab[j] : dintlv_tab[j]));
      exp_l = (j == K - 1);
      checks++;
      if (off + j >= got_data.size()) begin
        failures++;
        $display("FAIL %s_missing j=%0d got=none required=%0d", name, j, exp_d);
      end else if (got_data[off+j] !== exp_d || got_last[off+j] !== exp_l) begin
        failures++;
        $display("FAIL %s j=%0d got data=%0d last=%b required data=%0d last=%b",
                 name, j, got_data[off+j], got_last[off+j], exp_d, exp_l);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 11'sd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ready=%b valid=%b data=%0d last=%b required 0 0 0 0",
               in_ready, out_valid, out_data, out_last);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_interleave();
    out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    set_frame(0);
    write_frame(1'b0, 1'b0, K);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL intlv_latency_early got valid=%b required 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL intlv_latency got valid=%b required 1", out_valid);
    end
    wait_outputs(K, "intlv");
    check_frame("intlv", 0, 0, 1'b0);
  endtask

  task automatic test_deinterleave();
    out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    set_frame(100);
    write_frame(1'b1, 1'b0, K);
    wait_outputs(K, "dintlv");
    check_frame("dintlv", 0, 100, 1'b1);
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    out_ready = 1'b0;
    got_data.delete(); got_last.delete();
    acc_cnt = 0;
    repeat (100) begin
      in_valid = 1'b1;
      in_data  = 11'(200 + acc_cnt);
      mode     = 1'b0;
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt != 2 * K || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepted got=%0d ready=%b required=%0d ready=0", acc_cnt, in_ready, 2 * K);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 11'sd200) begin
      failures++;
      $display("FAIL bp_hold got valid=%b data=%0d required valid=1 data=200", out_valid, out_data);
    end
    out_ready = 1'b1;
    wait_outputs(2 * K, "bp");
    check_frame("bp_f1", 0, 200, 1'b0);
    check_frame("bp_f2", K, 221, 1'b0);
  endtask

  task automatic test_ping_pong();
    out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    write_cycles = 0;
    set_frame(0);
    write_frame(1'b0, 1'b1, K);
    set_frame(30);
    write_frame(1'b1, 1'b1, K);
    set_frame(60);
    write_frame(1'b0, 1'b0, K);
    checks++;
    if (write_cycles != 3 * K) begin
      failures++;
      $display("FAIL pp_write_cycles got=%0d required=%0d", write_cycles, 3 * K);
    end
    wait_outputs(3 * K, "pp");
    check_frame("pp_f0", 0, 0, 1'b0);
    check_frame("pp_f1", K, 30, 1'b1);
    check_frame("pp_f2", 2 * K, 60, 1'b0);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    got_data.delete(); got_last.delete();
    set_frame(400);
    write_frame(1'b0, 1'b0, K);
    write_frame(1'b1, 1'b0, 10);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b ready=%b last=%b required 0 0 0", out_valid, in_ready, out_last);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || got_data.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_idle got valid=%b count=%0d required valid=0 count=0", out_valid, got_data.size());
    end
    set_frame(500);
    write_frame(1'b0, 1'b0, K);
    wait_outputs(K, "mid");
    check_frame("mid", 0, 500, 1'b0);
  endtask

  task automatic test_scale();
    logic signed [10:0] exp_v[3];
`ifdef EXT_SCALE_EN
    exp_v = '{-11'sd6, 11'sd75, 11'sd766};
`else
    exp_v = '{-11'sd7, 11'sd100, 11'sd1023};
`endif
    out_ready = 1'b1;
    got_data.delete(); got_last.delete();
    set_frame(0);
    wdata[0] = -7; wdata[5] = 100; wdata[10] = 1023;
    write_frame(1'b0, 1'b0, K);
    wait_outputs(K, "scale");
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (j >= got_data.size() || got_data[j] !== exp_v[j]) begin
        failures++;
        $display("FAIL scale j=%0d got=%0d required=%0d", j,
                 (j < got_data.size()) ? got_data[j] : 11'sd0, exp_v[j]);
      end
    end
  endtask

  initial begin
    write_cycles = 0;
    test_reset();
    test_interleave();
    test_deinterleave();
    test_backpressure();
    test_ping_pong();
    test_reset_mid();
    test_scale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
